// File: rtl/envelope_pkg.sv
// rtl/envelope_pkg.sv - shared ADSR state encoding, default peak level and saturating step helper
package envelope_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } env_state_e;

   localparam int ENV_MAX_LEVEL = 256;

   // Working width for level arithmetic; wide enough that level + step never wraps
   // for any envelope width up to ENV_CALC_W-1 bits.
   localparam int ENV_CALC_W = 16;

   // Move level by step toward bound, stopping exactly at bound.
   // up=1: min(level + step, bound); up=0: max(level - step, bound).
   function automatic logic [ENV_CALC_W-1:0] sat_step(
      input logic [ENV_CALC_W-1:0] level,
      input logic [ENV_CALC_W-1:0] step,
      input logic [ENV_CALC_W-1:0] bound,
      input logic                  up
   );
      if (up) begin
         return ((level + step) >= bound) ? bound : (level + step);
      end
      return (level >= (bound + step)) ? (level - step) : bound;
   endfunction

endpackage

// File: rtl/edge_detector.sv
// rtl/edge_detector.sv - registered-history rise/fall detector for a level signal
module edge_detector (
   input  logic clk_i,
   input  logic reset_i,
   input  logic sig_i,
   output logic rise_o,
   output logic fall_o
);

   logic prev_q;
   logic armed_q;

   // Track the previous sample; arm rise detection only after the signal has been seen low,
   // so a level already high when reset releases does not count as a rising edge.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         prev_q <= sig_i;
         if (!sig_i) begin
            armed_q <= 1'b1;
         end
      end
   end

   assign rise_o = sig_i & ~prev_q & armed_q;
   assign fall_o = ~sig_i & prev_q;

endmodule

// File: rtl/envelope_generator.sv
// rtl/envelope_generator.sv - per-channel ADSR envelope FSM; ENVELOPE_RETRIGGER_EN enables re-attack on re-press
module envelope_generator
   import envelope_pkg::*;
#(
   parameter int WIDTH     = 9,
   parameter int MAX_LEVEL = ENV_MAX_LEVEL
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_tick,
   input  logic             i_gate,
   input  logic [7:0]       i_attack_step,
   input  logic [7:0]       i_decay_step,
   input  logic [WIDTH-1:0] i_sustain,
   input  logic [7:0]       i_release_step,
   output logic [WIDTH-1:0] o_envelope,
   output logic             o_active,
   output logic             o_done
);

   localparam int CW = ENV_CALC_W;
   localparam logic [CW-1:0] MAX_C = CW'(MAX_LEVEL);

   env_state_e       state_q, state_d;
   logic [WIDTH-1:0] level_q, level_d;
   logic             active_q;
   logic             done_q, done_d;
   logic             gate_rise, gate_fall;

   logic [CW-1:0] level_c;
   logic [CW-1:0] sustain_c;
   logic [CW-1:0] nxt;

   edge_detector u_gate_edge (
      .clk_i   (i_clk),
      .reset_i (i_reset),
      .sig_i   (i_gate),
      .rise_o  (gate_rise),
      .fall_o  (gate_fall)
   );

   assign level_c   = CW'(level_q);
   assign sustain_c = (CW'(i_sustain) > MAX_C) ? MAX_C : CW'(i_sustain);

   // Next state and level: gate edges take priority over a coincident tick.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      done_d  = 1'b0;
      nxt     = level_c;
      unique case (state_q)
         ST_IDLE: begin
            level_d = '0;
            if (gate_rise) begin
               state_d = ST_ATTACK;
            end
         end
         ST_ATTACK: begin
            if (gate_fall) begin
               state_d = ST_RELEASE;
            end else if (i_tick) begin
               nxt = (i_attack_step == 8'd0) ? MAX_C
                   : sat_step(level_c, CW'(i_attack_step), MAX_C, 1'b1);
               level_d = WIDTH'(nxt);
               if (nxt == MAX_C) begin
                  state_d = ST_DECAY;
               end
            end
         end
         ST_DECAY: begin
            if (gate_fall) begin
               state_d = ST_RELEASE;
`ifdef ENVELOPE_RETRIGGER_EN
            end else if (gate_rise) begin
               state_d = ST_ATTACK;
`endif
            end else if (i_tick) begin
               nxt = (i_decay_step == 8'd0 || level_c <= sustain_c) ? sustain_c
                   : sat_step(level_c, CW'(i_decay_step), sustain_c, 1'b0);
               level_d = WIDTH'(nxt);
               if (nxt == sustain_c) begin
                  state_d = ST_SUSTAIN;
               end
            end
         end
         ST_SUSTAIN: begin
            if (gate_fall) begin
               state_d = ST_RELEASE;
`ifdef ENVELOPE_RETRIGGER_EN
            end else if (gate_rise) begin
               state_d = ST_ATTACK;
`endif
            end else if (i_tick) begin
               level_d = WIDTH'(sustain_c);
            end
         end
         ST_RELEASE: begin
`ifdef ENVELOPE_RETRIGGER_EN
            if (gate_rise) begin
               state_d = ST_ATTACK;
            end else
`endif
            if (i_tick) begin
               nxt = (i_release_step == 8'd0) ? '0
                   : sat_step(level_c, CW'(i_release_step), '0, 1'b0);
               level_d = WIDTH'(nxt);
               if (nxt == '0) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            level_d = '0;
         end
      endcase
   end

   // State, level and registered status flags.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= ST_IDLE;
         level_q  <= '0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         level_q  <= level_d;
         active_q <= (state_d != ST_IDLE);
         done_q   <= done_d;
      end
   end

   assign o_envelope = level_q;
   assign o_active   = active_q;
   assign o_done     = done_q;

endmodule

// File: tb/tb_envelope_generator.sv
// tb/tb_envelope_generator.sv - directed self-checking bench for envelope_generator
module tb_envelope_generator;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic       gate;
   logic [7:0] attack_step;
   logic [7:0] decay_step;
   logic [8:0] sustain;
   logic [7:0] release_step;
   logic [8:0] envelope;
   logic       active;
   logic       done;

   int checks = 0;
   int errors = 0;

   envelope_generator #(.WIDTH(9), .MAX_LEVEL(256)) dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_tick         (tick),
      .i_gate         (gate),
      .i_attack_step  (attack_step),
      .i_decay_step   (decay_step),
      .i_sustain      (sustain),
      .i_release_step (release_step),
      .o_envelope     (envelope),
      .o_active       (active),
      .o_done         (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
   endtask

   task automatic tick_expect(input string tag, input logic [15:0] exp);
      pulse_tick();
      check(tag, 16'(envelope), exp);
      cyc(9);
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; gate = 1'b0;
      attack_step = 8'd64; decay_step = 8'd32; sustain = 9'd128; release_step = 8'd16;
      cyc(2);
      check("reset_env", 16'(envelope), 16'd0);
      check("reset_active", 16'(active), 16'd1 - 16'd1);
      check("reset_done", 16'(done), 16'd0);
      reset = 1'b0;
      cyc(2);

      // Attack 64 per tick up to 256, decay 32 per tick down to 128
      gate = 1'b1;
      cyc(1);
      check("gate_on_active", 16'(active), 16'd1);
      check("gate_on_env", 16'(envelope), 16'd0);
      cyc(9);
      tick_expect("atk1", 16'd64);
      tick_expect("atk2", 16'd128);
      tick_expect("atk3", 16'd192);
      tick_expect("atk4", 16'd256);
      tick_expect("dec1", 16'd224);
      tick_expect("dec2", 16'd192);
      tick_expect("dec3", 16'd160);
      tick_expect("dec4", 16'd128);
      tick_expect("sus_hold1", 16'd128);
      tick_expect("sus_hold2", 16'd128);
      sustain = 9'd100;
      tick_expect("sus_track", 16'd100);
      sustain = 9'd128;
      tick_expect("sus_back", 16'd128);

      // Release 16 per tick: 8 ticks from 128 to 0
      gate = 1'b0;
      cyc(1);
      check("rel_entry_env", 16'(envelope), 16'd128);
      check("rel_entry_active", 16'(active), 16'd1);
      cyc(9);
      for (int k = 1; k <= 7; k++) begin
         pulse_tick();
         check("rel_env", 16'(envelope), 16'(128 - 16 * k));
         check("rel_done_low", 16'(done), 16'd0);
         cyc(9);
      end
      pulse_tick();
      check("rel_zero_env", 16'(envelope), 16'd0);
      check("rel_zero_done", 16'(done), 16'd1);
      check("rel_zero_active", 16'(active), 16'd0);
      cyc(1);
      check("done_one_cycle", 16'(done), 16'd0);
      cyc(8);

      // All steps zero: 256, then sustain, then 0 after gate falls
      attack_step = 8'd0; decay_step = 8'd0; release_step = 8'd0; sustain = 9'd300;
      gate = 1'b1;
      cyc(10);
      tick_expect("z_atk", 16'd256);
      tick_expect("z_dec_clamped", 16'd256);
      sustain = 9'd128;
      tick_expect("z_sus", 16'd128);
      gate = 1'b0;
      cyc(10);
      pulse_tick();
      check("z_rel_env", 16'(envelope), 16'd0);
      check("z_rel_done", 16'(done), 16'd1);
      cyc(9);

      // Gate fall coincident with tick in SUSTAIN at 128
      attack_step = 8'd128; decay_step = 8'd64; release_step = 8'd48;
      gate = 1'b1;
      cyc(10);
      tick_expect("c_atk1", 16'd128);
      tick_expect("c_atk2", 16'd256);
      tick_expect("c_dec", 16'd192);
      tick_expect("c_sus", 16'd128);
      gate = 1'b0;
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      check("c_coinc_env", 16'(envelope), 16'd128);
      check("c_coinc_active", 16'(active), 16'd1);
      cyc(9);
      tick_expect("c_rel1", 16'd80);

      // Re-press during RELEASE at 80
      gate = 1'b1;
      cyc(1);
      check("rp_env_hold", 16'(envelope), 16'd80);
      check("rp_active", 16'(active), 16'd1);
      cyc(9);
`ifdef ENVELOPE_RETRIGGER_EN
      tick_expect("rp_attack", 16'd208);
      tick_expect("rp_peak", 16'd256);
`else
      tick_expect("rp_release", 16'd32);
      pulse_tick();
      check("rp_zero_env", 16'(envelope), 16'd0);
      check("rp_zero_done", 16'(done), 16'd1);
      cyc(9);
      tick_expect("rp_idle_gate_held", 16'd0);
      check("rp_idle_active", 16'(active), 16'd0);
`endif

      // Reset mid-ATTACK
      reset = 1'b1;
      gate = 1'b0;
      cyc(1);
      reset = 1'b0;
      cyc(2);
      attack_step = 8'd100;
      gate = 1'b1;
      cyc(10);
      tick_expect("ra_atk", 16'd100);
      reset = 1'b1;
      cyc(1);
      check("ra_env", 16'(envelope), 16'd0);
      check("ra_active", 16'(active), 16'd0);
      check("ra_done", 16'(done), 16'd0);

      // Gate high through reset release yields no rising edge
      cyc(1);
      reset = 1'b0;
      cyc(2);
      tick_expect("gh_env", 16'd0);
      check("gh_active", 16'(active), 16'd0);
      gate = 1'b0;
      cyc(2);
      gate = 1'b1;
      cyc(1);
      check("gh_rearm_active", 16'(active), 16'd1);
      cyc(9);
      tick_expect("gh_atk", 16'd100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
